// File: rtl/truth_table_sweeper.sv
// Self-test sequencer for a 3-input logic stage: sweeps x through all eight codes,
// captures the delayed stage output and error flag, and reports a signature and verdict.
module truth_table_sweeper #(
   parameter logic [7:0] TRUTH_TABLE = 8'b00111001,
   // Register stages between z and d_in; legal range 1..4.
   parameter int         LATENCY     = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   output logic [2:0] x_out,
   input  logic       d_in,
   input  logic       err_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] mismatch_count,
   output logic       err_seen,
   output logic [2:0] first_fail_x,
   output logic       first_fail_valid,
   output logic [7:0] signature
);

   // Handshake: start is a level request honoured only in IDLE; done is a one-cycle
   // pulse, and every result output stays stable from done until the next accepted start.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   // Tag pipeline: entry j holds the code launched j+1 edges ago.
   logic [LATENCY:0]      tag_v;
   logic [LATENCY:0][2:0] tag_x;

   logic       launch_v;
   logic [2:0] launch_x;
   logic       err_hit;
   logic       smp_v;
   logic [2:0] smp_x;
   logic       smp_bad;
   logic       final_sample;
   logic [3:0] mm_nx;
   logic       err_nx;

   always_comb begin
      err_hit      = tag_v[0] & err_in;
      smp_v        = tag_v[LATENCY];
      smp_x        = tag_x[LATENCY];
      smp_bad      = smp_v && (d_in != TRUTH_TABLE[smp_x]);
      final_sample = smp_v && (smp_x == 3'd7);
      mm_nx        = mismatch_count;
      if (smp_bad && (mismatch_count != 4'd8))
         mm_nx = mismatch_count + 4'd1;
      err_nx       = err_seen | err_hit;
   end

   always_comb begin
      state_nx = state;
      launch_v = 1'b0;
      launch_x = 3'd0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = DRIVE;
               launch_v = 1'b1;
               launch_x = 3'd0;
            end
         end
         DRIVE: begin
            if (x_out == 3'd7) begin
               state_nx = DRAIN;
            end else begin
               launch_v = 1'b1;
               launch_x = x_out + 3'd1;
            end
         end
         DRAIN: begin
            if (final_sample)
               state_nx = REPORT;
         end
         REPORT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         tag_v <= '0;
         tag_x <= '0;
      end else begin
         state <= state_nx;
         tag_v <= {tag_v[LATENCY-1:0], launch_v};
         tag_x <= {tag_x[LATENCY-1:0], launch_x};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         x_out <= 3'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_out <= 3'd0;
                  busy  <= 1'b1;
                  pass  <= 1'b0;
               end
            end
            DRIVE: begin
               if (x_out != 3'd7)
                  x_out <= x_out + 3'd1;
            end
            DRAIN: begin
               if (final_sample) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  // Uses the next-state counters so the last sample is included.
                  pass <= (mm_nx == 4'd0) && !err_nx;
               end
            end
            REPORT: begin
               done  <= 1'b0;
               x_out <= 3'd0;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

   // Result registers: cleared on an accepted start, otherwise updated only by valid tags.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mismatch_count   <= 4'd0;
         err_seen         <= 1'b0;
         first_fail_x     <= 3'd0;
         first_fail_valid <= 1'b0;
         signature        <= 8'd0;
      end else if ((state == IDLE) && start) begin
         mismatch_count   <= 4'd0;
         err_seen         <= 1'b0;
         first_fail_x     <= 3'd0;
         first_fail_valid <= 1'b0;
         signature        <= 8'd0;
      end else begin
         mismatch_count <= mm_nx;
         err_seen       <= err_nx;
         if (smp_v)
            signature[smp_x] <= d_in;
         if (smp_bad && !first_fail_valid) begin
            first_fail_x     <= smp_x;
            first_fail_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (LATENCY 2 and 3) driving a stage model
// with selectable faults, checked every cycle against a time-based result model.
module tb_truth_table_sweeper;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic chk_en  = 1'b0;

   logic [1:0] start_v  = '0;
   logic [1:0] erren_v  = '0;
   int         mode_a [2];

   logic [1:0][2:0] x_v;
   logic [1:0][2:0] ffx_v;
   logic [1:0][3:0] mm_v;
   logic [1:0][7:0] sig_v;
   logic [1:0]      busy_v, done_v, pass_v, err_v, ffv_v;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // Stage behaviour: 0 = correct, 1 = z inverted at x=5, 2 = z stuck at 0.
   function automatic logic fz(input int mode, input int k);
      logic [7:0] tt;
      tt = 8'b00111001;
      case (mode)
         0:       return tt[k];
         1:       return tt[k] ^ (k == 5);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int clamp8(input int v);
      if (v < 0) return 0;
      if (v > 8) return 8;
      return v;
   endfunction

   task automatic check(input string name, input int lat, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s L=%0d got=%0d want=%0d at %0t", name, lat, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g
      localparam int L = 2 + gi;

      logic          d_in, err_in, z;
      logic [L-1:0]  dl = '0;
      int            t = -1;
      int            m_mode = 0;
      logic          m_err = 1'b0;

      assign z      = fz(mode_a[gi], int'(x_v[gi]));
      assign err_in = erren_v[gi] && (x_v[gi] == 3'd3);
      assign d_in   = dl[L-1];

      always @(posedge clock) dl <= {dl[L-2:0], z};

      truth_table_sweeper #(.TRUTH_TABLE(8'b00111001), .LATENCY(L)) dut (
         .clock            (clock),
         .reset_n          (reset_n),
         .start            (start_v[gi]),
         .x_out            (x_v[gi]),
         .d_in             (d_in),
         .err_in           (err_in),
         .busy             (busy_v[gi]),
         .done             (done_v[gi]),
         .pass             (pass_v[gi]),
         .mismatch_count   (mm_v[gi]),
         .err_seen         (err_v[gi]),
         .first_fail_x     (ffx_v[gi]),
         .first_fail_valid (ffv_v[gi]),
         .signature        (sig_v[gi])
      );

      // Model time: t = edges since the accepted start (-1 after reset).
      // The sequencer is idle before an edge when t<0 or t>=9+L.
      always @(posedge clock) begin
         if (!reset_n) begin
            t <= -1;
         end else if ((t < 0 || t >= 9 + L) && start_v[gi]) begin
            t      <= 0;
            m_mode <= mode_a[gi];
            m_err  <= erren_v[gi];
         end else if (t >= 0 && t < 100000) begin
            t <= t + 1;
         end
      end

      int         ns, ne, e_mm, e_ffx, e_x;
      logic       e_ffv, e_err, e_pass, e_busy, e_done;
      logic [7:0] e_sig, tt_l;

      always @(negedge clock) begin
         if (chk_en) begin
            tt_l  = 8'b00111001;
            ns    = clamp8(t - L);
            ne    = clamp8(t);
            e_sig = '0; e_mm = 0; e_ffv = 1'b0; e_ffx = 0;
            for (int k = 0; k < 8; k++) begin
               if (k < ns) begin
                  e_sig[k] = fz(m_mode, k);
                  if (e_sig[k] != tt_l[k]) begin
                     e_mm++;
                     if (!e_ffv) begin e_ffv = 1'b1; e_ffx = k; end
                  end
               end
            end
            e_err  = m_err && (ne > 3);
            e_pass = (t >= 8 + L) && (e_mm == 0) && !e_err;
            e_busy = (t >= 0) && (t <= 7 + L);
            e_done = (t == 8 + L);
            if (t < 0)           e_x = 0;
            else if (t <= 7)     e_x = t;
            else if (t <= 8 + L) e_x = 7;
            else                 e_x = 0;
            check("x_out",  L, int'(x_v[gi]),   e_x);
            check("busy",   L, int'(busy_v[gi]), int'(e_busy));
            check("done",   L, int'(done_v[gi]), int'(e_done));
            check("pass",   L, int'(pass_v[gi]), int'(e_pass));
            check("mm",     L, int'(mm_v[gi]),   e_mm);
            check("err",    L, int'(err_v[gi]),  int'(e_err));
            check("ffv",    L, int'(ffv_v[gi]),  int'(e_ffv));
            check("ffx",    L, int'(ffx_v[gi]),  e_ffx);
            check("sig",    L, int'(sig_v[gi]),  int'(e_sig));
         end
      end
   end

   // Pulse start, optionally re-pulse at edge S+mid_t, and count edges from S to done.
   task automatic sweep(input int i, input int mid_t, output int cnt);
      @(negedge clock); start_v[i] = 1'b1;
      @(negedge clock); start_v[i] = 1'b0;
      cnt = 0;
      while (!done_v[i] && cnt < 30) begin
         start_v[i] = (cnt == mid_t - 1);
         @(negedge clock);
         cnt++;
      end
      start_v[i] = 1'b0;
   endtask

   task automatic pin(input int i, input int sig, input int mm, input int ffv,
                      input int ffx, input int err, input int ps);
      check("pin_sig",  2 + i, int'(sig_v[i]), sig);
      check("pin_mm",   2 + i, int'(mm_v[i]),  mm);
      check("pin_ffv",  2 + i, int'(ffv_v[i]), ffv);
      if (ffv != 0) check("pin_ffx", 2 + i, int'(ffx_v[i]), ffx);
      check("pin_err",  2 + i, int'(err_v[i]), err);
      check("pin_pass", 2 + i, int'(pass_v[i]), ps);
   endtask

   int cnt, cnt2;

   initial begin
      mode_a[0] = 0; mode_a[1] = 0;
      repeat (3) @(negedge clock);
      chk_en  = 1'b1;
      check("rst_x",   2, int'(x_v[0]),   0);
      check("rst_sig", 2, int'(sig_v[0]), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Correct stage
      sweep(0, -1, cnt);
      check("lat_done", 2, cnt, 10);
      pin(0, 8'h39, 0, 0, 0, 0, 1);

      // z inverted at x=5
      @(negedge clock); mode_a[0] = 1;
      sweep(0, -1, cnt);
      check("lat_done", 2, cnt, 10);
      pin(0, 8'h19, 1, 1, 5, 0, 0);

      // z stuck at 0
      @(negedge clock); mode_a[0] = 2;
      sweep(0, -1, cnt);
      pin(0, 8'h00, 4, 1, 0, 0, 0);

      // Error flag at x=3 plus an ignored start at S+4
      @(negedge clock); mode_a[0] = 0; erren_v[0] = 1'b1;
      sweep(0, 4, cnt);
      check("lat_midstart", 2, cnt, 10);
      pin(0, 8'h39, 0, 0, 0, 1, 0);
      @(negedge clock); erren_v[0] = 1'b0;

      // Reset at S+6 mid-sweep
      @(negedge clock); start_v[0] = 1'b1;
      @(negedge clock); start_v[0] = 1'b0;
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check("rst_mid_x",    2, int'(x_v[0]),    0);
      check("rst_mid_busy", 2, int'(busy_v[0]), 0);
      check("rst_mid_sig",  2, int'(sig_v[0]),  0);
      reset_n = 1'b1;
      repeat (6) @(negedge clock);
      sweep(0, -1, cnt);
      check("lat_after_rst", 2, cnt, 10);
      pin(0, 8'h39, 0, 0, 0, 0, 1);

      // LATENCY=3 instance, then start held high for back-to-back sweeps
      sweep(1, -1, cnt);
      check("lat_done", 3, cnt, 11);
      pin(1, 8'h39, 0, 0, 0, 0, 1);
      @(negedge clock); start_v[1] = 1'b1;
      @(negedge clock);
      cnt = 0;
      while (!done_v[1] && cnt < 30) begin @(negedge clock); cnt++; end
      check("lat_held1", 3, cnt, 11);
      cnt2 = 0;
      do begin @(negedge clock); cnt2++; end while (!done_v[1] && cnt2 < 40);
      start_v[1] = 1'b0;
      check("lat_held_gap", 3, cnt2, 13);
      pin(1, 8'h39, 0, 0, 0, 0, 1);

      repeat (20) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
